stepper_cmd_seq: RTL

- Command sequencer directly upstream of the stepper pulse generator.
- Queues host motion commands and runs a homing sequence against a limit switch.
- Drives the stepper's 32-bit control word {speed[7:0], goal[23:0]} and its homing_enable.
- Watches the stepper's feedback_position to report move completion.
- All host positions are relative to the home point; the block applies the home offset internally.

---
 rtl/stepper_cmd_seq.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/stepper_cmd_seq.sv
// stepper_cmd_seq
//   Command sequencer that sits directly in front of the stepper pulse
//   generator. Host commands (moves and homing requests) are queued in a
//   small FIFO and executed one at a time. Homing runs against a debounced
//   limit switch and captures the home offset. Every host position is
//   relative to that home point, and the offset is added before the goal
//   is handed to the stepper.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   cmd_valid/ready     host command handshake (ready = FIFO not full)
//   cmd_home            1 = homing request, 0 = move
//   cmd_speed, cmd_pos  move speed code and home-relative target
//   limit_sw            raw home switch, asynchronous to clk
//   feedback_position   stepper absolute position (bits [23:0] used)
//   control             {speed, absolute goal} to the stepper
//   homing_enable       stepper homing mode
//   busy                a command is running or waiting in the FIFO
//   done_pulse          one cycle when a move or homing completes
//   bad_cmd             one cycle when a queued command is rejected
//   homed               a valid home offset is held
//   fault               sticky homing timeout
//   rel_position        feedback position relative to home
module stepper_cmd_seq #(
    parameter int          DEPTH           = 4,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [31:0] HOME_TIMEOUT    = 32'd400_000_000,
    parameter int          SETTLE_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_home,
    input  logic [7:0]  cmd_speed,
    input  logic [23:0] cmd_pos,
    input  logic        limit_sw,
    input  logic [31:0] feedback_position,
    output logic [31:0] control,
    output logic        homing_enable,
    output logic        busy,
    output logic        done_pulse,
    output logic        bad_cmd,
    output logic        homed,
    output logic        fault,
    output logic [23:0] rel_position
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [AW:0]   FIFO_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE     = (AW+1)'(1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [31:0]   HOME_LAST   = HOME_TIMEOUT - 32'd1;

    typedef enum logic [1:0] {IDLE, HOMING, MOVE} state_t;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fifo_home  [DEPTH];
    logic [7:0]    fifo_speed [DEPTH];
    logic [23:0]   fifo_pos   [DEPTH];

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          head_home;
    logic [7:0]    head_speed;
    logic [23:0]   head_pos;
    logic          speed_ok;

    logic          sync_ff1;
    logic          sync_ff2;
    logic          limit_filt;
    logic [DW-1:0] deb_cnt;

    logic [23:0]   home_offset;
    logic [31:0]   home_cnt;
    logic [SW-1:0] settle_cnt;
    logic [23:0]   fb_pos;
    logic          fb_unused_bits;

    assign fb_pos         = feedback_position[23:0];
    assign fb_unused_bits = ^feedback_position[31:24];

    assign full      = (count == FIFO_FULL);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    // The head is consumed whenever IDLE looks at it, whether it runs or is rejected.
    assign pop       = (state == IDLE) && !empty;
    assign busy      = (state != IDLE) || !empty;

    assign head_home  = fifo_home[rd_ptr];
    assign head_speed = fifo_speed[rd_ptr];
    assign head_pos   = fifo_pos[rd_ptr];

    // Legal speed codes: a contiguous low range plus three spot values.
    assign speed_ok = (head_speed <= 8'd40) || (head_speed == 8'd45) ||
                      (head_speed == 8'd50) || (head_speed == 8'd55);

    // FIFO payload storage; only the pointers need a reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_home[wr_ptr]  <= cmd_home;
            fifo_speed[wr_ptr] <= cmd_speed;
            fifo_pos[wr_ptr]   <= cmd_pos;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Limit switch: two-flop synchroniser, then the filtered value only follows
    // after the synchronised value has disagreed for a full unbroken window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_ff1   <= 1'b0;
            sync_ff2   <= 1'b0;
            limit_filt <= 1'b0;
            deb_cnt    <= '0;
        end else begin
            sync_ff1 <= limit_sw;
            sync_ff2 <= sync_ff1;
            if (sync_ff2 != limit_filt) begin
                if (deb_cnt >= DEB_LAST) begin
                    limit_filt <= sync_ff2;
                    deb_cnt    <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Main sequencer. Control is written only when leaving IDLE, so the
    // stepper sees at most one new word per command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            control       <= '0;
            homing_enable <= 1'b0;
            done_pulse    <= 1'b0;
            bad_cmd       <= 1'b0;
            homed         <= 1'b0;
            fault         <= 1'b0;
            home_offset   <= '0;
            home_cnt      <= '0;
            settle_cnt    <= '0;
        end else begin
            done_pulse <= 1'b0;
            bad_cmd    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (head_home) begin
                            // Park the goal on the current position so the
                            // stepper stays put once homing mode drops.
                            state         <= HOMING;
                            homing_enable <= 1'b1;
                            control       <= {control[31:24], fb_pos};
                            home_cnt      <= '0;
                        end else if (!homed || !speed_ok) begin
                            bad_cmd <= 1'b1;
                        end else begin
                            state      <= MOVE;
                            control    <= {head_speed, head_pos + home_offset};
                            settle_cnt <= '0;
                        end
                    end
                end
                HOMING: begin
                    if (limit_filt) begin
                        homing_enable <= 1'b0;
                        home_offset   <= fb_pos;
                        homed         <= 1'b1;
                        fault         <= 1'b0;
                        done_pulse    <= 1'b1;
                        state         <= IDLE;
                    end else if (home_cnt >= HOME_LAST) begin
                        homing_enable <= 1'b0;
                        fault         <= 1'b1;
                        homed         <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        home_cnt <= home_cnt + 32'd1;
                    end
                end
                MOVE: begin
                    if (fb_pos == control[23:0]) begin
                        if (settle_cnt >= SETTLE_LAST) begin
                            done_pulse <= 1'b1;
                            settle_cnt <= '0;
                            state      <= IDLE;
                        end else begin
                            settle_cnt <= settle_cnt + SW'(1);
                        end
                    end else begin
                        settle_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Home-relative position report, wrapping mod 2^24.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rel_position <= '0;
        end else begin
            rel_position <= fb_pos - home_offset;
        end
    end

endmodule
